cnv2dp_fmt: RTL and testbench

Parametrised video-to-DisplayPort formatter for the native display pipeline. It normalises input sync polarity and width-converts each colour component, then packs pixels in DP order {B,R,G} over a configurable register pipeline. It adds frame-aligned output modes (pass-through, black mute, colour bars) and an active-area timing monitor for bring-up and status readback. It sits between the display timing/pixel source and the DP live-video input.

---
 rtl/cnv2dp_pkg.sv | 32 +++
 rtl/cnv2dp_timing_mon.sv | 102 ++++++++++
 rtl/cnv2dp_fmt.sv | 129 ++++++++++++
 tb/tb_cnv2dp_fmt.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnv2dp_pkg.sv
// Shared constants and helpers for the video-to-DisplayPort formatter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cnv2dp_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_BLACK = 2'd1;
    localparam logic [1:0] MODE_BARS  = 2'd2;

    // Colour-bar table, entry = {r,g,b}; index 0 is the leftmost bar.
    // Order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    // MSB-justified component width conversion. The input value sits in the
    // low in_bpc bits; the result sits in the low out_bpc bits.
    function automatic logic [15:0] bpc_conv(input logic [15:0] v,
                                             input int in_bpc,
                                             input int out_bpc);
        if (out_bpc >= in_bpc)
            return v << (out_bpc - in_bpc);
        else
            return v >> (in_bpc - out_bpc);
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

endpackage

// File: rtl/cnv2dp_timing_mon.sv
// Active-area monitor: measures pixels/line and lines/frame, flags unequal lines.
// Latency: STAT_* update on the vs_rise edge itself (not delayed by the data pipe).
// Backpressure: none; observes the input timing only.
module cnv2dp_timing_mon
    import cnv2dp_pkg::*;
(
    input  logic        DCLK,
    input  logic        DRST,
    input  logic        de,
    input  logic        vs_rise,
    output logic [15:0] stat_hact,
    output logic [15:0] stat_vact,
    output logic        stat_valid,
    output logic        stat_err
);

    logic        de_q,    de_d;
    logic [15:0] hcnt_q,  hcnt_d;
    logic [15:0] vcnt_q,  vcnt_d;
    logic [15:0] href_q,  href_d;
    logic        err_q,   err_d;
    logic        armed_q, armed_d;
    logic [15:0] hact_q,  hact_d;
    logic [15:0] vact_q,  vact_d;
    logic        valid_q, valid_d;
    logic        serr_q,  serr_d;

    // Line accounting first, then frame close; a line ending on the vs_rise
    // cycle is folded into the frame being closed. The first vs_rise after
    // reset only opens a frame, since what preceded it is a partial frame.
    always_comb begin
        de_d    = de;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        href_d  = href_q;
        err_d   = err_q;
        armed_d = armed_q;
        hact_d  = hact_q;
        vact_d  = vact_q;
        valid_d = valid_q;
        serr_d  = serr_q;

        if (de)
            hcnt_d = sat_inc(hcnt_q);

        if (!de && de_q) begin
            vcnt_d = sat_inc(vcnt_q);
            if (vcnt_q == 16'd0)
                href_d = hcnt_q;
            else if (hcnt_q != href_q)
                err_d = 1'b1;
            hcnt_d = '0;
        end

        if (vs_rise) begin
            if (armed_q) begin
                hact_d  = href_d;
                vact_d  = vcnt_d;
                valid_d = (vcnt_d != 16'd0);
                serr_d  = err_d;
            end
            armed_d = 1'b1;
            href_d  = '0;
            vcnt_d  = '0;
            hcnt_d  = '0;
            err_d   = 1'b0;
        end
    end

    // Monitor state registers with synchronous reset.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            de_q    <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            href_q  <= '0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
            hact_q  <= '0;
            vact_q  <= '0;
            valid_q <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            de_q    <= de_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            href_q  <= href_d;
            err_q   <= err_d;
            armed_q <= armed_d;
            hact_q  <= hact_d;
            vact_q  <= vact_d;
            valid_q <= valid_d;
            serr_q  <= serr_d;
        end
    end

    assign stat_hact  = hact_q;
    assign stat_vact  = vact_q;
    assign stat_valid = valid_q;
    assign stat_err   = serr_q;

endmodule

// File: rtl/cnv2dp_fmt.sv
// Video-to-DP formatter: sync normalisation, width conversion, {B,R,G} packing, test modes.
// Latency: PIPE DCLK cycles for DP_*; STAT_* change on the vsync rising edge.
// Backpressure: none; the DP live-video sink must accept one pixel every DCLK.
module cnv2dp_fmt
    import cnv2dp_pkg::*;
#(
    parameter int IN_BPC  = 8,
    parameter int OUT_BPC = 12,
    parameter int PIPE    = 1,
    parameter int BAR_W   = 160
) (
    input  logic                   DCLK,
    input  logic                   DRST,
    input  logic                   DSP_HSYNC_X,
    input  logic                   DSP_VSYNC_X,
    input  logic                   DSP_DE,
    input  logic [IN_BPC-1:0]      DSP_R,
    input  logic [IN_BPC-1:0]      DSP_G,
    input  logic [IN_BPC-1:0]      DSP_B,
    input  logic                   CFG_HPOL,
    input  logic                   CFG_VPOL,
    input  logic [1:0]             CFG_MODE,
    output logic                   DP_HSYNC,
    output logic                   DP_VSYNC,
    output logic                   DP_DE,
    output logic [3*OUT_BPC-1:0]   DP_DAT,
    output logic [15:0]            STAT_HACT,
    output logic [15:0]            STAT_VACT,
    output logic                   STAT_VALID,
    output logic                   STAT_ERR
);

    localparam int DW = 3 * OUT_BPC;
    localparam int SW = DW + 3;

    logic                hs, vs, vs_rise;
    logic                vs_q,   vs_d;
    logic [1:0]          mode_q, mode_d;
    logic [15:0]         hpos_q, hpos_d;
    logic [OUT_BPC-1:0]  r_c, g_c, b_c;
    logic [15:0]         bar_div;
    logic [2:0]          bar_idx;
    logic [2:0]          bar_rgb;
    logic [DW-1:0]       bar_dat;
    logic [DW-1:0]       dat;
    logic [SW-1:0]       pipe_q [PIPE];
    logic [SW-1:0]       pipe_d [PIPE];

    assign hs      = DSP_HSYNC_X ^ ~CFG_HPOL;
    assign vs      = DSP_VSYNC_X ^ ~CFG_VPOL;
    assign vs_rise = vs & ~vs_q;

    assign r_c = OUT_BPC'(bpc_conv(16'(DSP_R), IN_BPC, OUT_BPC));
    assign g_c = OUT_BPC'(bpc_conv(16'(DSP_G), IN_BPC, OUT_BPC));
    assign b_c = OUT_BPC'(bpc_conv(16'(DSP_B), IN_BPC, OUT_BPC));

    // Mode is sampled only at frame start so a frame never mixes modes;
    // hpos restarts at every DE-low gap.
    always_comb begin
        vs_d   = vs;
        mode_d = vs_rise ? CFG_MODE : mode_q;
        hpos_d = DSP_DE ? sat_inc(hpos_q) : 16'd0;
    end

    // Bar colour for the current pixel, expanded to full-scale components.
    always_comb begin
        bar_div = hpos_q / 16'(BAR_W);
        bar_idx = (bar_div > 16'd7) ? 3'd7 : bar_div[2:0];
        bar_rgb = BAR_RGB[bar_idx];
        bar_dat = {{OUT_BPC{bar_rgb[0]}}, {OUT_BPC{bar_rgb[2]}}, {OUT_BPC{bar_rgb[1]}}};
    end

    // Pixel data selection; blanking always carries zero data.
    always_comb begin
        dat = '0;
        if (DSP_DE) begin
            case (mode_q)
                MODE_BLACK: dat = '0;
                MODE_BARS:  dat = bar_dat;
                default:    dat = {b_c, r_c, g_c};
            endcase
        end
    end

    // Shift-register feed: syncs, DE and data travel together.
    always_comb begin
        pipe_d[0] = {hs, vs, DSP_DE, dat};
        for (int i = 1; i < PIPE; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    // Control registers with synchronous reset.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            vs_q   <= 1'b0;
            mode_q <= MODE_PASS;
            hpos_q <= '0;
        end else begin
            vs_q   <= vs_d;
            mode_q <= mode_d;
            hpos_q <= hpos_d;
        end
    end

    // Output pipeline registers with synchronous reset.
    always_ff @(posedge DCLK) begin
        if (DRST) begin
            for (int i = 0; i < PIPE; i++)
                pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < PIPE; i++)
                pipe_q[i] <= pipe_d[i];
        end
    end

    assign {DP_HSYNC, DP_VSYNC, DP_DE, DP_DAT} = pipe_q[PIPE-1];

    cnv2dp_timing_mon u_mon (
        .DCLK       (DCLK),
        .DRST       (DRST),
        .de         (DSP_DE),
        .vs_rise    (vs_rise),
        .stat_hact  (STAT_HACT),
        .stat_vact  (STAT_VACT),
        .stat_valid (STAT_VALID),
        .stat_err   (STAT_ERR)
    );

endmodule

// File: tb/tb_cnv2dp_fmt.sv
// Directed bench for cnv2dp_fmt: packing, polarity, modes, monitor, reset.
// Latency: DUT instantiated with PIPE=1, so outputs are sampled 1 ns after the next edge.
// Backpressure: none exercised; the DUT has no ready path.
module tb_cnv2dp_fmt;

    localparam int IN_BPC  = 8;
    localparam int OUT_BPC = 12;
    localparam int PIPE    = 1;
    localparam int BAR_W   = 2;

    logic                 DCLK = 1'b0;
    logic                 DRST = 1'b1;
    logic                 DSP_HSYNC_X = 1'b0;
    logic                 DSP_VSYNC_X = 1'b0;
    logic                 DSP_DE = 1'b0;
    logic [IN_BPC-1:0]    DSP_R = '0;
    logic [IN_BPC-1:0]    DSP_G = '0;
    logic [IN_BPC-1:0]    DSP_B = '0;
    logic                 CFG_HPOL = 1'b1;
    logic                 CFG_VPOL = 1'b1;
    logic [1:0]           CFG_MODE = 2'd0;
    logic                 DP_HSYNC, DP_VSYNC, DP_DE;
    logic [3*OUT_BPC-1:0] DP_DAT;
    logic [15:0]          STAT_HACT, STAT_VACT;
    logic                 STAT_VALID, STAT_ERR;

    int n_pass  = 0;
    int n_total = 0;
    logic [35:0] bar_exp [8];

    cnv2dp_fmt #(.IN_BPC(IN_BPC), .OUT_BPC(OUT_BPC), .PIPE(PIPE), .BAR_W(BAR_W)) dut (
        .DCLK(DCLK), .DRST(DRST),
        .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X), .DSP_DE(DSP_DE),
        .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
        .CFG_HPOL(CFG_HPOL), .CFG_VPOL(CFG_VPOL), .CFG_MODE(CFG_MODE),
        .DP_HSYNC(DP_HSYNC), .DP_VSYNC(DP_VSYNC), .DP_DE(DP_DE), .DP_DAT(DP_DAT),
        .STAT_HACT(STAT_HACT), .STAT_VACT(STAT_VACT),
        .STAT_VALID(STAT_VALID), .STAT_ERR(STAT_ERR)
    );

    always #5 DCLK = ~DCLK;

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic do_reset();
        DRST = 1'b1;
        tick();
        DRST = 1'b0;
    endtask

    task automatic set_pix(input logic de, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        DSP_DE = de; DSP_R = r; DSP_G = g; DSP_B = b;
    endtask

    task automatic line(input int n);
        set_pix(1'b1, 8'h11, 8'h22, 8'h33);
        repeat (n) tick();
        DSP_DE = 1'b0;
        repeat (2) tick();
    endtask

    task automatic vs_pulse();
        DSP_VSYNC_X = 1'b1;
        repeat (2) tick();
        DSP_VSYNC_X = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        set_pix(1'b1, 8'h5A, 8'hC3, 8'h7E);
        DSP_HSYNC_X = 1'b1;
        DRST = 1'b1;
        repeat (2) tick();
        n_total++; if (DP_DE !== 1'b0) $display("FAIL rst_de: got %b want 0", DP_DE); else n_pass++;
        n_total++; if (DP_DAT !== 36'h0) $display("FAIL rst_dat: got %h want 0", DP_DAT); else n_pass++;
        n_total++; if (DP_HSYNC !== 1'b0) $display("FAIL rst_hs: got %b want 0", DP_HSYNC); else n_pass++;
        n_total++; if ({STAT_HACT, STAT_VACT, STAT_VALID, STAT_ERR} !== 34'h0)
            $display("FAIL rst_stat: got %h/%h/%b/%b want 0", STAT_HACT, STAT_VACT, STAT_VALID, STAT_ERR); else n_pass++;
        DRST = 1'b0;
        DSP_HSYNC_X = 1'b0;
        DSP_DE = 1'b0;
    endtask

    task automatic test_packing();
        set_pix(1'b1, 8'hA5, 8'h3C, 8'hFF);
        n_total++; if (DP_DE !== 1'b0) $display("FAIL pack_early: got de=%b want 0", DP_DE); else n_pass++;
        tick();
        n_total++; if (DP_DAT !== 36'hFF0A503C0) $display("FAIL pack_dat: got %h want ff0a503c0", DP_DAT); else n_pass++;
        n_total++; if (DP_DE !== 1'b1) $display("FAIL pack_de: got %b want 1", DP_DE); else n_pass++;
        set_pix(1'b1, 8'h01, 8'h80, 8'h00);
        tick();
        n_total++; if (DP_DAT !== 36'h000010800) $display("FAIL pack_dat2: got %h want 000010800", DP_DAT); else n_pass++;
        set_pix(1'b0, 8'hA5, 8'h3C, 8'hFF);
        tick();
        n_total++; if (DP_DAT !== 36'h0) $display("FAIL blank_dat: got %h want 0", DP_DAT); else n_pass++;
        n_total++; if (DP_DE !== 1'b0) $display("FAIL blank_de: got %b want 0", DP_DE); else n_pass++;
    endtask

    task automatic test_polarity();
        CFG_HPOL = 1'b0; DSP_HSYNC_X = 1'b0; tick();
        n_total++; if (DP_HSYNC !== 1'b1) $display("FAIL hpol0_lo: got %b want 1", DP_HSYNC); else n_pass++;
        DSP_HSYNC_X = 1'b1; tick();
        n_total++; if (DP_HSYNC !== 1'b0) $display("FAIL hpol0_hi: got %b want 0", DP_HSYNC); else n_pass++;
        CFG_HPOL = 1'b1; tick();
        n_total++; if (DP_HSYNC !== 1'b1) $display("FAIL hpol1_hi: got %b want 1", DP_HSYNC); else n_pass++;
        DSP_HSYNC_X = 1'b0; tick();
        CFG_VPOL = 1'b0; DSP_VSYNC_X = 1'b0; tick();
        n_total++; if (DP_VSYNC !== 1'b1) $display("FAIL vpol0_lo: got %b want 1", DP_VSYNC); else n_pass++;
        DSP_VSYNC_X = 1'b1; tick();
        n_total++; if (DP_VSYNC !== 1'b0) $display("FAIL vpol0_hi: got %b want 0", DP_VSYNC); else n_pass++;
        CFG_VPOL = 1'b1; tick();
        n_total++; if (DP_VSYNC !== 1'b1) $display("FAIL vpol1_hi: got %b want 1", DP_VSYNC); else n_pass++;
        DSP_VSYNC_X = 1'b0; repeat (2) tick();
    endtask

    task automatic test_mode_switch();
        bar_exp = '{36'hFFFFFFFFF, 36'h000FFFFFF, 36'hFFF000FFF, 36'h000000FFF,
                    36'hFFFFFF000, 36'h000FFF000, 36'hFFF000000, 36'h000000000};
        CFG_MODE = 2'd1;
        set_pix(1'b1, 8'hA5, 8'h3C, 8'hFF); tick();
        n_total++; if (DP_DAT !== 36'hFF0A503C0) $display("FAIL mode_mid: got %h want ff0a503c0", DP_DAT); else n_pass++;
        DSP_DE = 1'b0; tick();
        vs_pulse();
        DSP_DE = 1'b1; tick();
        n_total++; if (DP_DAT !== 36'h0) $display("FAIL black_dat: got %h want 0", DP_DAT); else n_pass++;
        n_total++; if (DP_DE !== 1'b1) $display("FAIL black_de1: got %b want 1", DP_DE); else n_pass++;
        DSP_DE = 1'b0; tick();
        n_total++; if (DP_DE !== 1'b0) $display("FAIL black_de0: got %b want 0", DP_DE); else n_pass++;
        CFG_MODE = 2'd2;
        vs_pulse();
        for (int i = 0; i < 16; i++) begin
            DSP_DE = 1'b1; tick();
            n_total++; if (DP_DAT !== bar_exp[i/2]) $display("FAIL bar_px%0d: got %h want %h", i, DP_DAT, bar_exp[i/2]); else n_pass++;
        end
        DSP_DE = 1'b0; repeat (2) tick();
        CFG_MODE = 2'd3;
        vs_pulse();
        set_pix(1'b1, 8'h12, 8'h34, 8'h56); tick();
        n_total++; if (DP_DAT !== 36'h560120340) $display("FAIL mode3_dat: got %h want 560120340", DP_DAT); else n_pass++;
        DSP_DE = 1'b0; tick();
        CFG_MODE = 2'd0;
        vs_pulse();
    endtask

    task automatic test_monitor();
        do_reset();
        line(16); line(16);
        vs_pulse();
        n_total++; if (STAT_VALID !== 1'b0 || STAT_VACT !== 16'd0)
            $display("FAIL mon_first_vs: got valid=%b vact=%0d want 0/0", STAT_VALID, STAT_VACT); else n_pass++;
        repeat (4) line(16);
        vs_pulse();
        n_total++; if (STAT_HACT !== 16'd16) $display("FAIL mon_hact: got %0d want 16", STAT_HACT); else n_pass++;
        n_total++; if (STAT_VACT !== 16'd4) $display("FAIL mon_vact: got %0d want 4", STAT_VACT); else n_pass++;
        n_total++; if (STAT_VALID !== 1'b1) $display("FAIL mon_valid: got %b want 1", STAT_VALID); else n_pass++;
        n_total++; if (STAT_ERR !== 1'b0) $display("FAIL mon_err0: got %b want 0", STAT_ERR); else n_pass++;
        line(16); line(16); line(15); line(16);
        vs_pulse();
        n_total++; if (STAT_ERR !== 1'b1) $display("FAIL mon_err1: got %b want 1", STAT_ERR); else n_pass++;
        n_total++; if (STAT_HACT !== 16'd16 || STAT_VACT !== 16'd4)
            $display("FAIL mon_err_geom: got %0d x %0d want 16 x 4", STAT_HACT, STAT_VACT); else n_pass++;
        repeat (4) line(16);
        vs_pulse();
        n_total++; if (STAT_ERR !== 1'b0) $display("FAIL mon_err_clr: got %b want 0", STAT_ERR); else n_pass++;
        repeat (10) tick();
        vs_pulse();
        n_total++; if (STAT_VALID !== 1'b0) $display("FAIL mon_empty_valid: got %b want 0", STAT_VALID); else n_pass++;
        n_total++; if (STAT_HACT !== 16'd0 || STAT_VACT !== 16'd0)
            $display("FAIL mon_empty_geom: got %0d x %0d want 0 x 0", STAT_HACT, STAT_VACT); else n_pass++;
        line(16);
        n_total++; if (STAT_VALID !== 1'b0 || STAT_VACT !== 16'd0)
            $display("FAIL mon_stable: got valid=%b vact=%0d want 0/0", STAT_VALID, STAT_VACT); else n_pass++;
    endtask

    task automatic test_edge_coincidence();
        vs_pulse();
        repeat (3) line(16);
        DSP_DE = 1'b1; repeat (16) tick();
        DSP_DE = 1'b0; DSP_VSYNC_X = 1'b1; repeat (2) tick();
        DSP_VSYNC_X = 1'b0; repeat (2) tick();
        n_total++; if (STAT_VACT !== 16'd4) $display("FAIL coinc_vact: got %0d want 4", STAT_VACT); else n_pass++;
        n_total++; if (STAT_HACT !== 16'd16 || STAT_ERR !== 1'b0)
            $display("FAIL coinc_hact: got %0d err=%b want 16 err=0", STAT_HACT, STAT_ERR); else n_pass++;
        repeat (4) line(16);
        DSP_DE = 1'b1; repeat (5) tick();
        DSP_VSYNC_X = 1'b1; tick();
        DSP_DE = 1'b0; tick();
        DSP_VSYNC_X = 1'b0; repeat (2) tick();
        n_total++; if (STAT_VACT !== 16'd4 || STAT_ERR !== 1'b0)
            $display("FAIL partial_drop: got vact=%0d err=%b want 4/0", STAT_VACT, STAT_ERR); else n_pass++;
    endtask

    task automatic test_reset_mid();
        CFG_MODE = 2'd1;
        vs_pulse();
        set_pix(1'b1, 8'hA5, 8'h3C, 8'hFF); tick();
        n_total++; if (DP_DAT !== 36'h0) $display("FAIL rm_black: got %h want 0", DP_DAT); else n_pass++;
        DRST = 1'b1; tick();
        n_total++; if (DP_DE !== 1'b0 || DP_DAT !== 36'h0)
            $display("FAIL rm_out: got de=%b dat=%h want 0/0", DP_DE, DP_DAT); else n_pass++;
        n_total++; if (STAT_VACT !== 16'd0 || STAT_VALID !== 1'b0)
            $display("FAIL rm_stat: got vact=%0d valid=%b want 0/0", STAT_VACT, STAT_VALID); else n_pass++;
        DRST = 1'b0; tick();
        n_total++; if (DP_DAT !== 36'hFF0A503C0) $display("FAIL rm_mode_pass: got %h want ff0a503c0", DP_DAT); else n_pass++;
        DSP_DE = 1'b0; repeat (2) tick();
        CFG_MODE = 2'd0;
        line(16); line(16);
        vs_pulse();
        n_total++; if (STAT_VALID !== 1'b0) $display("FAIL rm_first_vs: got %b want 0", STAT_VALID); else n_pass++;
        repeat (3) line(16);
        vs_pulse();
        n_total++; if (STAT_VACT !== 16'd3 || STAT_VALID !== 1'b1)
            $display("FAIL rm_second_vs: got vact=%0d valid=%b want 3/1", STAT_VACT, STAT_VALID); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_packing();
        test_polarity();
        test_mode_switch();
        test_monitor();
        test_edge_coincidence();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
